// File: rtl/riscv_defines.sv
// Shared core definitions: MDU operation codes and the MDU sequencer states.
package riscv_defines;

    localparam int unsigned MDU_OP_WIDTH = 3;
    localparam int unsigned ALU_OP_WIDTH = MDU_OP_WIDTH + 1;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // The top opcode bit separates the divide family from the multiply family.
    function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[MDU_OP_WIDTH-1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One add/subtract step of the iterative multiplier/divider.
module mdu_step #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] res,
    output logic         cout
);

    logic [W:0] sum;

    // For subtraction cout is the no-borrow flag (a >= b).
    always_comb begin
        sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W+1)'(sub);
    end

    assign res  = sum[W-1:0];
    assign cout = sum[W];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring-divide steps
// on operand magnitudes, followed by a sign-fix cycle.
module mdu_iter
    import riscv_defines::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic [XLEN-1:0]         op_a_i,
    input  logic [XLEN-1:0]         op_b_i,
    input  logic                    flush_i,
    output logic [XLEN-1:0]         result_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int unsigned CNT_W  = $clog2(XLEN);
    localparam int unsigned STEP_W = XLEN + 1;

    mdu_state_t              state;
    logic [MDU_OP_WIDTH-1:0] op;
    logic                    neg_a;
    logic                    neg_b;
    logic [CNT_W-1:0]        cnt;
    logic [XLEN-1:0]         acc_hi;
    logic [XLEN-1:0]         acc_lo;
    logic [XLEN-1:0]         opnd;

    logic                    in_is_div;
    logic                    in_a_signed;
    logic                    in_b_signed;
    logic                    in_neg_a;
    logic                    in_neg_b;
    logic [XLEN-1:0]         in_abs_a;
    logic [XLEN-1:0]         in_abs_b;
    logic                    in_special;
    logic [XLEN-1:0]         in_special_res;

    logic [STEP_W-1:0]       step_a;
    logic [STEP_W-1:0]       step_b;
    logic                    step_sub;
    logic [STEP_W-1:0]       step_res;
    logic                    step_cout;
    logic [XLEN-1:0]         acc_hi_nx;
    logic [XLEN-1:0]         acc_lo_nx;

    logic [2*XLEN-1:0]       product;
    logic [2*XLEN-1:0]       prod_fix;
    logic [XLEN-1:0]         quot_fix;
    logic [XLEN-1:0]         rem_fix;
    logic [XLEN-1:0]         fix_res;

    assign ready_o = (state == IDLE);

    // Accept-side decode: signedness, magnitudes and the divide special cases.
    always_comb begin
        in_is_div      = mdu_is_div(mdu_op_i);
        in_a_signed    = (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU) ||
                         (mdu_op_i == MDU_DIV)  || (mdu_op_i == MDU_REM);
        in_b_signed    = (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_DIV) ||
                         (mdu_op_i == MDU_REM);
        in_neg_a       = in_a_signed && op_a_i[XLEN-1];
        in_neg_b       = in_b_signed && op_b_i[XLEN-1];
        in_abs_a       = in_neg_a ? -op_a_i : op_a_i;
        in_abs_b       = in_neg_b ? -op_b_i : op_b_i;
        in_special     = 1'b0;
        in_special_res = '0;
        if (in_is_div) begin
            if (op_b_i == '0) begin
                // Opcode bit 1 distinguishes REM/REMU from DIV/DIVU.
                in_special     = 1'b1;
                in_special_res = mdu_op_i[1] ? op_a_i : '1;
            end else if (((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM)) &&
                         (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1)) begin
                in_special     = 1'b1;
                in_special_res = mdu_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end
    end

    // Multiply: acc_hi accumulates, acc_lo holds the multiplier shifting out.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    always_comb begin
        step_a    = {1'b0, acc_hi};
        step_b    = acc_lo[0] ? {1'b0, opnd} : '0;
        step_sub  = 1'b0;
        acc_hi_nx = step_res[STEP_W-1:1];
        acc_lo_nx = {step_res[0], acc_lo[XLEN-1:1]};
        if (mdu_is_div(op)) begin
            step_a    = {acc_hi, acc_lo[XLEN-1]};
            step_b    = {1'b0, opnd};
            step_sub  = 1'b1;
            acc_hi_nx = step_cout ? step_res[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
            acc_lo_nx = {acc_lo[XLEN-2:0], step_cout};
        end
    end

    mdu_step #(
        .W (STEP_W)
    ) u_step (
        .a    (step_a),
        .b    (step_b),
        .sub  (step_sub),
        .res  (step_res),
        .cout (step_cout)
    );

    // Sign correction and result-half selection for the FIX cycle.
    always_comb begin
        product  = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -product : product;
        quot_fix = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_fix  = neg_a ? -acc_hi : acc_hi;
        case (op)
            MDU_MUL:                          fix_res = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_res = quot_fix;
            default:                          fix_res = rem_fix;
        endcase
    end

    // Sequencer, step counter, operand registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op    <= mdu_op_i;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        if (in_special) begin
                            result_o <= in_special_res;
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt    <= CNT_W'(XLEN - 1);
                            acc_hi <= '0;
                            acc_lo <= in_is_div ? in_abs_a : in_abs_b;
                            opnd   <= in_is_div ? in_abs_b : in_abs_a;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= acc_hi_nx;
                    acc_lo <= acc_lo_nx;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_o <= fix_res;
                    valid_o  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: results, latency, handshake stall, flush and reset.
module tb_mdu_iter;
    import riscv_defines::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    valid_i;
    logic                    ready_o;
    logic [MDU_OP_WIDTH-1:0] mdu_op_i;
    logic [31:0]             op_a_i;
    logic [31:0]             op_b_i;
    logic                    flush_i;
    logic [31:0]             result_o;
    logic                    valid_o;
    logic                    ready_i;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .mdu_op_i (mdu_op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, measure latency, check result and handshake.
    task automatic run_op(input string tag, input logic [MDU_OP_WIDTH-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res, input int hold);
        int   lat;
        logic busy_low;
        chk({tag, " ready before"}, 64'(ready_o), 64'(1));
        mdu_op_i = op;
        op_a_i   = a;
        op_b_i   = b;
        valid_i  = 1'b1;
        ready_i  = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        valid_i  = 1'b0;
        lat      = 0;
        busy_low = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            if (ready_o !== 1'b0) busy_low = 1'b0;
            if (valid_o === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy"}, 64'(busy_low), 64'(1));
        chk({tag, " result"}, 64'(result_o), 64'(exp_res));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " stall hold"}, 64'({valid_o, result_o}), 64'({1'b1, exp_res}));
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk({tag, " valid drop"}, 64'(valid_o), 64'(0));
        chk({tag, " ready after"}, 64'(ready_o), 64'(1));
    endtask

    initial begin
        logic saw_valid;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        mdu_op_i = '0;
        op_a_i   = '0;
        op_b_i   = '0;
        flush_i  = 1'b0;
        ready_i  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(ready_o), 64'(1));
        chk("reset valid", 64'(valid_o), 64'(0));
        chk("reset result", 64'(result_o), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL",     MDU_MUL,    32'd7,        32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 0);
        run_op("MULH",    MDU_MULH,   32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 0);
        run_op("MULHSU",  MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 0);
        run_op("MULHU",   MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 0);
        run_op("DIV",     MDU_DIV,    32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFD, 0);
        run_op("REM",     MDU_REM,    32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 0);
        run_op("DIVU",    MDU_DIVU,   32'd7,        32'd2,        34, 32'd3,         0);
        run_op("REMU",    MDU_REMU,   32'd7,        32'd2,        34, 32'd1,         0);
        run_op("DIV0",    MDU_DIV,    32'd5,        32'd0,        1,  32'hFFFF_FFFF, 0);
        run_op("REMU0",   MDU_REMU,   32'd5,        32'd0,        1,  32'd5,         0);
        run_op("DIVOVF",  MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, 0);
        run_op("REMOVF",  MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'd0,         0);

        // Flush ten cycles into a divide.
        mdu_op_i = MDU_DIVU;
        op_a_i   = 32'd1000;
        op_b_i   = 32'd3;
        valid_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush ready", 64'(ready_o), 64'(1));
        chk("flush valid", 64'(valid_o), 64'(0));
        saw_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) saw_valid = 1'b1;
        end
        chk("flush no valid", 64'(saw_valid), 64'(0));
        run_op("MULHU post flush", MDU_MULHU, 32'd3, 32'd5, 34, 32'd0, 0);

        // Flush alongside valid in IDLE must block the accept.
        mdu_op_i = MDU_DIV;
        op_a_i   = 32'd5;
        op_b_i   = 32'd0;
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush+valid ready", 64'(ready_o), 64'(1));
        saw_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) saw_valid = 1'b1;
        end
        chk("flush+valid no valid", 64'(saw_valid), 64'(0));

        // Writeback stall for five cycles.
        run_op("DIVU stall", MDU_DIVU, 32'd100, 32'd7, 34, 32'd14, 5);

        // Asynchronous reset in the middle of CALC.
        mdu_op_i = MDU_MUL;
        op_a_i   = 32'd6;
        op_b_i   = 32'd7;
        valid_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid calc busy", 64'(ready_o), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 64'(valid_o), 64'(0));
        chk("async rst result", 64'(result_o), 64'(0));
        chk("async rst ready", 64'(ready_o), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("MUL after reset", MDU_MUL, 32'd6, 32'd7, 34, 32'd42, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit for the execute stage. Consumes the `mdu_op` code and the `mdu_op_ctrl` select that the decode controller produces. Computes all eight M-extension operations with a shared 32-step shift-add/shift-subtract datapath. Returns the 32-bit result to writeback through a valid/ready handshake, and stalls the pipeline while busy.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1: core clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_i`  in  1: the operation on `mdu_op_i`, `op_a_i`, `op_b_i` is valid. Driven from the controller's `mdu_op_ctrl` gated by the stage valid.
- `ready_o`  out  1: unit can accept an operation; high only in IDLE.
- `mdu_op_i`  in  MDU_OP_WIDTH (3): MDU_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `op_a_i`, `op_b_i`  in  32: rs1, rs2.
- `flush_i`  in  1: abort any in-flight operation.
- `result_o`  out  32: result; valid while `valid_o`.
- `valid_o`  out  1: result available; held until accepted.
- `ready_i`  in  1: writeback accepts the result.

## Operation
- **Accept:** `valid_i && ready_o && !flush_i`. On the accept edge the unit latches the op, sign flags, and operand magnitudes (|a|, |b|) according to the signedness of the op.
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - MUL, MULHU, DIVU, REMU: unsigned.
- **States:** IDLE, CALC, FIX, DONE.
  - IDLE → CALC on accept. The step counter loads 31.
  - IDLE → DONE on accept of a special divide. The result is loaded directly.
  - CALC: one step per cycle. Counter decrements. At count 0 → FIX.
  - FIX: apply the sign correction and select the output half → DONE.
  - DONE: `valid_o`=1. If `ready_i` → IDLE.
- **Multiply:** 64-bit accumulator. Each step adds the multiplicand when the multiplier LSB is set, then shifts right. MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32]. The 64-bit product is two's-complement negated when the result sign (sa^sb) is 1.
- **Divide:** restoring division with a 33-bit partial remainder. Each step shifts in the next dividend bit and subtracts the divisor if no borrow; the quotient bit is !borrow.
  - Quotient is negated if sa^sb (DIV).
  - Remainder is negated if sa (REM).
- **Special cases** (resolved at accept, no CALC):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a_i`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **Flush:** `flush_i` in any state → IDLE on the next edge. `valid_o` drops. Flush has priority over accept and over `ready_i` in the same cycle.
- **Reset values:** state IDLE, `valid_o`=0, `result_o`=0, `ready_o`=1, counter 0, accumulators 0. The reset is asynchronous: outputs take these values immediately on assertion, including mid-CALC.

## Timing
- Accept at edge t0 (normal path):
  - CALC in cycles t0+1 … t0+32.
  - FIX at t0+33.
  - `valid_o` rises at t0+34, for a latency of 34 cycles.
- Special divide path: `valid_o` at t0+1.
- `result_o` and `valid_o` stay stable while `ready_i`=0.
- Back-to-back operations: the result is accepted at edge t, `ready_o` is high in cycle t+1, and the next accept is at t+1. This gives one bubble per operation.
- `ready_o` is a pure function of state (no combinational path from `valid_i`).
- All outputs are registered, except `ready_o`, which is decoded from the state register.

## Structure
- Shared package `riscv_defines` holds:
  - `MDU_OP_WIDTH`;
  - the MDU_* constants, which must stay consistent with ALU_OP_WIDTH = MDU_OP_WIDTH+1;
  - the `mdu_state_t` enum {IDLE, CALC, FIX, DONE}.
- One sub-module is natural: `mdu_step`. It is a combinational 33-bit add/subtract step shared by multiply and divide and instantiated once.
- The FSM, counter, and sign logic live in `mdu_iter`.

## Test plan
- **Multiply, low word:** MUL 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB. `valid_o` exactly 34 cycles after accept; `ready_o`=0 throughout.
- **Multiply, high word:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- **Divide, rounding and signs:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7,2 → 0xFFFFFFFF.
  - DIVU 7/2 → 3.
  - REMU 7,2 → 1.
- **Special divides:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000,−1 → 0.
  - Each completes 1 cycle after accept.
- **Flush mid-operation:** `flush_i` pulse 10 cycles after accept → `valid_o` never rises and `ready_o`=1 on the next cycle. A following MULHU 3×5 → 0 at t0+34. A flush asserted together with `valid_i` in IDLE → the op is not accepted.
- **Handshake stall and reset:**
  - Hold `ready_i`=0 for 5 cycles after `valid_o` → result stable, then accepted.
  - Assert `rst_n`=0 mid-CALC → `valid_o`=0, `result_o`=0, `ready_o`=1 immediately.
